// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   PORT0/PORT1      : port identifiers used for the grant pointer and response routing
//   DEPTH_DEF etc.   : default macro geometry (2048 x 16)
//   req_t            : request bundle {we, addr, wdata} at the default geometry
package sram_arb_pkg;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned DEPTH_DEF  = 2048;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with registered last-grant pointer.
//   CLK, reset     : clock and asynchronous active-high reset
//   valid0, valid1 : request pending on port 0 / 1
//   gnt            : one-hot grant, gnt[0] = port 0, gnt[1] = port 1; all-zero in reset
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic       valid0,
  input  logic       valid1,
  output logic [1:0] gnt
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt        = 2'b00;
    last_gnt_d = last_gnt_q;
    if (!reset) begin
      // On contention the port that did not win last time gets the grant.
      gnt[0] = valid0 && (!valid1 || (last_gnt_q == PORT1));
      gnt[1] = valid1 && (!valid0 || (last_gnt_q == PORT0));
    end
    if (gnt[1])      last_gnt_d = PORT1;
    else if (gnt[0]) last_gnt_d = PORT0;
  end

  // Reset to PORT1 so that port 0 wins the first contention.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) last_gnt_q <= PORT1;
    else       last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/sram.sv
// Behavioural model of the single-port SRAM macro.
//   CLK : clock, rising edge
//   CEN : chip enable, active low
//   WEN : write enable, active low (0 = write)
//   A   : word address, captured at the edge for reads
//   D   : write data
//   Q   : read data for the last captured read address
module sram #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] a_q;

  always_ff @(posedge CLK) begin
    if (!CEN && !WEN) mem[A] <= D;
    if (!CEN && WEN)  a_q    <= A;
  end

  assign Q = mem[a_q];

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port SRAM.
//   CLK, reset                  : clock and asynchronous active-high reset
//   req{0,1}_valid/ready        : request handshake, completes on valid & ready
//   req{0,1}_we/addr/wdata      : request payload (we = 1 write, 0 read)
//   rsp{0,1}_valid, rsp_data    : read response strobe per port, shared data bus
//   sram_cen/wen/a/d, sram_q    : SRAM macro drive and read data
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_bus_t;

  logic [1:0] gnt;
  req_bus_t   req0, req1, sel;
  logic       any_gnt;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_port_q, rd_port_d;

  rr_arb2 u_arb (
    .CLK    (CLK),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt    (gnt)
  );

  assign req0       = {req0_we, req0_addr, req0_wdata};
  assign req1       = {req1_we, req1_addr, req1_wdata};
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    sel       = gnt[1] ? req1 : req0;
    any_gnt   = |gnt;
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    rd_pend_d = 1'b0;
    rd_port_d = rd_port_q;
    if (any_gnt) begin
      sram_cen = 1'b0;
      sram_wen = ~sel.we;
      sram_a   = sel.addr;
      sram_d   = sel.wdata;
      if (!sel.we) begin
        rd_pend_d = 1'b1;
        rd_port_d = gnt[1] ? PORT1 : PORT0;
      end
    end
  end

  // Response pipeline: the SRAM presents data the cycle after the read grant.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= PORT0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  assign rsp0_valid = rd_pend_q && (rd_port_q == PORT0);
  assign rsp1_valid = rd_pend_q && (rd_port_q == PORT1);
  assign rsp_data   = sram_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter driving a behavioural sram.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 11;

  logic              CLK = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic              req0_we, req1_we;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              sram_cen, sram_wen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d, sram_q;

  int checks = 0;
  int errors = 0;
  logic [16:0] sb [$];  // {port, data}

  always #5 CLK = ~CLK;

  sram_arbiter #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .CLK (CLK),
    .CEN (sram_cen),
    .WEN (sram_wen),
    .A   (sram_a),
    .D   (sram_d),
    .Q   (sram_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is seen.
  always @(negedge CLK) begin
    logic [16:0] e;
    chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {rsp1_valid, rsp0_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", 32'(rsp1_valid), 32'(e[16]));
        chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
      end
    end
  end

  // One cycle of stimulus starting at posedge+1; checks grants at negedge and
  // queues the hand-computed read data for a granted read.
  task automatic step(input logic v0, input req_t r0, input logic v1, input req_t r1,
                      input logic eg0, input logic eg1, input logic [15:0] exp_rd);
    req_t g;
    req0_valid = v0; req0_we = r0.we; req0_addr = r0.addr; req0_wdata = r0.wdata;
    req1_valid = v1; req1_we = r1.we; req1_addr = r1.addr; req1_wdata = r1.wdata;
    @(negedge CLK);
    chk("req0_ready", 32'(req0_ready), 32'(eg0));
    chk("req1_ready", 32'(req1_ready), 32'(eg1));
    chk("sram_cen", 32'(sram_cen), 32'(!(eg0 || eg1)));
    if (eg0 || eg1) begin
      g = eg1 ? r1 : r0;
      chk("sram_wen", 32'(sram_wen), 32'(!g.we));
      chk("sram_a", 32'(sram_a), 32'(g.addr));
      if (g.we) chk("sram_d", 32'(sram_d), 32'(g.wdata));
      else      sb.push_back({eg1, exp_rd});
    end else begin
      chk("idle_wen", 32'(sram_wen), 32'd1);
      chk("idle_a", 32'(sram_a), 32'd0);
    end
    @(posedge CLK);
    #1;
  endtask

  localparam req_t NONE   = '0;
  localparam req_t W_BEEF = '{we: 1'b1, addr: 11'h005, wdata: 16'hBEEF};
  localparam req_t R_005  = '{we: 1'b0, addr: 11'h005, wdata: 16'h0000};
  localparam req_t W_1111 = '{we: 1'b1, addr: 11'h010, wdata: 16'h1111};
  localparam req_t W_2222 = '{we: 1'b1, addr: 11'h020, wdata: 16'h2222};
  localparam req_t R_010  = '{we: 1'b0, addr: 11'h010, wdata: 16'h0000};
  localparam req_t R_020  = '{we: 1'b0, addr: 11'h020, wdata: 16'h0000};
  localparam req_t W_7FF  = '{we: 1'b1, addr: 11'h7FF, wdata: 16'h00A3};
  localparam req_t R_7FF  = '{we: 1'b0, addr: 11'h7FF, wdata: 16'h0000};

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;

    // Reset then idle.
    repeat (3) begin
      @(negedge CLK);
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      chk("rst_ready1", 32'(req1_ready), 32'd0);
      chk("rst_rsp", {rsp1_valid, rsp0_valid}, 32'd0);
      chk("rst_cen", 32'(sram_cen), 32'd1);
      chk("rst_wen", 32'(sram_wen), 32'd1);
    end
    @(posedge CLK); #1;
    reset = 1'b0;
    step(0, NONE, 0, NONE, 0, 0, 16'h0);
    step(0, NONE, 0, NONE, 0, 0, 16'h0);

    // Single-port write then read.
    step(1, W_BEEF, 0, NONE, 1, 0, 16'h0);
    step(1, R_005, 0, NONE, 1, 0, 16'hBEEF);
    step(0, NONE, 0, NONE, 0, 0, 16'h0);

    // Preload, then sustained contention: strict alternation from port 0.
    step(1, W_1111, 0, NONE, 1, 0, 16'h0);
    step(0, NONE, 1, W_2222, 0, 1, 16'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, R_010, 1, R_020, 1, 0, 16'h1111);
      else            step(1, R_010, 1, R_020, 0, 1, 16'h2222);
    end
    step(0, NONE, 0, NONE, 0, 0, 16'h0);

    // Write then read of the same (last) address on the next cycle.
    step(0, NONE, 1, W_7FF, 0, 1, 16'h0);
    step(1, R_7FF, 0, NONE, 1, 0, 16'h00A3);
    step(0, NONE, 0, NONE, 0, 0, 16'h0);

    // Reset asserted during a port 1 read grant: no response may appear.
    req1_valid = 1; req1_we = 0; req1_addr = 11'h020;
    @(negedge CLK);
    chk("midrst_grant", 32'(req1_ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready_gated", 32'(req1_ready), 32'd0);
    chk("midrst_cen_gated", 32'(sram_cen), 32'd1);
    @(posedge CLK); #1;
    req1_valid = 0;
    @(negedge CLK);
    chk("midrst_rsp1", 32'(rsp1_valid), 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    step(0, NONE, 0, NONE, 0, 0, 16'h0);
    step(1, R_010, 1, R_020, 1, 0, 16'h1111);
    step(1, R_010, 1, R_020, 0, 1, 16'h2222);
    step(0, NONE, 0, NONE, 0, 0, 16'h0);
    step(0, NONE, 0, NONE, 0, 0, 16'h0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
